// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring integer divider with start/ready
// handshake, per-transaction signed/unsigned selection, divide-by-zero and
// signed-overflow flags. Optional abort port under `DIV_ITER_ABORT_EN.
module div_iter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef DIV_ITER_ABORT_EN
  input  logic             i_abort,
`endif
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_zero,
  output logic             o_overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_rem;      // partial remainder, always < divisor
  logic [WIDTH-1:0] r_quo;      // dividend shifts out MSB first, quotient shifts in
  logic [WIDTH-1:0] r_dvs;      // divisor magnitude
  logic [WIDTH-1:0] r_dvd_raw;  // original dividend bits for special cases
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_ovf;

  logic             r_valid;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;
  logic             r_dz_out;
  logic             r_ovf_out;

  logic             w_abort;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_is_min;
  logic [WIDTH+1:0] w_ext;
  logic [WIDTH+1:0] w_sub;
  logic             w_qbit;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

`ifdef DIV_ITER_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // Operand magnitudes and special-case detection at accept time
  always_comb begin
    w_a_neg  = i_signed & i_dividend[WIDTH-1];
    w_b_neg  = i_signed & i_divisor[WIDTH-1];
    w_a_mag  = w_a_neg ? -i_dividend : i_dividend;
    w_b_mag  = w_b_neg ? -i_divisor  : i_divisor;
    w_is_min = (i_dividend == {1'b1, {(WIDTH-1){1'b0}}});
  end

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  // The subtraction is one bit wider than the shifted remainder so its MSB is the borrow.
  always_comb begin
    w_ext     = {r_rem, r_quo[WIDTH-1]};
    w_sub     = w_ext - {2'b00, r_dvs};
    w_qbit    = ~w_sub[WIDTH+1];
    w_rem_nxt = w_qbit ? w_sub[WIDTH:0] : w_ext[WIDTH:0];
  end

  // Sign correction and special-case selection for the final result
  always_comb begin
    if (r_dz) begin
      w_q_fix = '1;
      w_r_fix = r_dvd_raw;
    end else if (r_ovf) begin
      w_q_fix = r_dvd_raw;
      w_r_fix = '0;
    end else begin
      w_q_fix = r_neg_q ? -r_quo : r_quo;
      w_r_fix = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    end
  end

  // Control FSM, datapath iteration and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_dvd_raw <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      r_ovf     <= 1'b0;
      r_valid   <= 1'b0;
      r_q_out   <= '0;
      r_r_out   <= '0;
      r_dz_out  <= 1'b0;
      r_ovf_out <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_rem     <= '0;
              r_quo     <= w_a_mag;
              r_dvs     <= w_b_mag;
              r_dvd_raw <= i_dividend;
              r_neg_q   <= w_a_neg ^ w_b_neg;
              r_neg_r   <= w_a_neg;
              r_dz      <= (i_divisor == '0);
              r_ovf     <= i_signed & w_is_min & (&i_divisor);
              r_cnt     <= CNT_W'(WIDTH - 1);
              r_state   <= S_CALC;
            end
          end
          S_CALC: begin
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[WIDTH-2:0], w_qbit};
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_state <= S_FIX;
            end
          end
          S_FIX: begin
            r_q_out   <= w_q_fix;
            r_r_out   <= w_r_fix;
            r_dz_out  <= r_dz;
            r_ovf_out <= r_ovf;
            r_valid   <= 1'b1;
            r_state   <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_ready     = (r_state == S_IDLE);
  assign o_valid     = r_valid;
  assign o_quotient  = r_q_out;
  assign o_remainder = r_r_out;
  assign o_div_zero  = r_dz_out;
  assign o_overflow  = r_ovf_out;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: scoreboard bench for div_iter (WIDTH=8). Expected results are
// queued when an operation is accepted and compared when o_valid pulses.
module tb_div_iter;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         i_start;
  logic         i_signed;
  logic [W-1:0] i_dividend;
  logic [W-1:0] i_divisor;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_quotient;
  logic [W-1:0] o_remainder;
  logic         o_div_zero;
  logic         o_overflow;
`ifdef DIV_ITER_ABORT_EN
  logic         i_abort;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  div_iter #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef DIV_ITER_ABORT_EN
    .i_abort     (i_abort),
`endif
    .i_start     (i_start),
    .i_signed    (i_signed),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_div_zero  (o_div_zero),
    .o_overflow  (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model built from language arithmetic, special cases first
  function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.dz  = 1'b0;
    e.ovf = 1'b0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (sgn && a == 8'h80 && b == 8'hFF) begin
      e.q = a; e.r = '0; e.ovf = 1'b1;
    end else if (sgn) begin
      e.q = W'($signed(a) / $signed(b));
      e.r = W'($signed(a) % $signed(b));
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Result monitor: every o_valid must match the oldest queued expectation
  always @(negedge clk) begin
    if (o_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("quotient",  32'(o_quotient),  32'(e.q));
        check_eq("remainder", 32'(o_remainder), 32'(e.r));
        check_eq("div_zero",  32'(o_div_zero),  32'(e.dz));
        check_eq("overflow",  32'(o_overflow),  32'(e.ovf));
        check_eq("ready_with_valid", 32'(o_ready), 32'd1);
      end
    end
  end

  // Issue one op, queue its expectation, check latency/ready/pulse width
  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input logic eovf, input bit full_timing);
    exp_t e;
    int   lat;
    bit   busy_ok;
    @(negedge clk);
    check_eq("ready_idle", 32'(o_ready), 32'd1);
    i_signed = sgn; i_dividend = a; i_divisor = b; i_start = 1'b1;
    e.q = eq; e.r = er; e.dz = edz; e.ovf = eovf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    i_start    = 1'b0;
    i_signed   = ~sgn;
    i_dividend = W'($urandom);
    i_divisor  = W'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 20) begin
      @(negedge clk);
      if (o_valid) break;
      if (o_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(W + 1));
    if (full_timing) begin
      check_eq("ready_low_while_busy", 32'(busy_ok), 32'd1);
      @(negedge clk);
      check_eq("valid_one_cycle", 32'(o_valid), 32'd0);
    end
  endtask

  initial begin
    exp_t e;
    int   accepts;
    int   guard;
    bit   stray;
    reset = 1'b1; i_start = 1'b0; i_signed = 1'b0; i_dividend = '0; i_divisor = '0;
`ifdef DIV_ITER_ABORT_EN
    i_abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 32'(o_ready), 32'd1);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_q",     32'(o_quotient), 32'd0);
    check_eq("rst_r",     32'(o_remainder), 32'd0);
    check_eq("rst_flags", 32'({o_div_zero, o_overflow}), 32'd0);

    // Directed cases
    run_op(1'b0, 8'd200, 8'd7,  8'd28,  8'd4,   1'b0, 1'b0, 1'b1);
    run_op(1'b1, 8'hF9,  8'h02, 8'hFD,  8'hFF,  1'b0, 1'b0, 1'b0);
    run_op(1'b1, 8'h07,  8'hFE, 8'hFD,  8'h01,  1'b0, 1'b0, 1'b0);
    run_op(1'b1, 8'hF9,  8'hFE, 8'h03,  8'hFF,  1'b0, 1'b0, 1'b0);
    run_op(1'b0, 8'd249, 8'd2,  8'd124, 8'd1,   1'b0, 1'b0, 1'b0);
    run_op(1'b0, 8'd5,   8'd0,  8'hFF,  8'd5,   1'b1, 1'b0, 1'b0);
    run_op(1'b1, 8'hFB,  8'h00, 8'hFF,  8'hFB,  1'b1, 1'b0, 1'b0);
    run_op(1'b1, 8'h80,  8'hFF, 8'h80,  8'h00,  1'b0, 1'b1, 1'b0);
    run_op(1'b0, 8'd128, 8'd255, 8'd0,  8'd128, 1'b0, 1'b0, 1'b0);

    // Held i_start with changing operands: only ready edges accept
    accepts = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      i_start = 1'b1; i_signed = 1'b0;
      i_dividend = W'(5 + k); i_divisor = W'(2 + k);
      if (o_ready) begin
        sb_q.push_back(model(1'b0, i_dividend, i_divisor));
        accepts++;
      end
    end
    @(negedge clk);
    i_start = 1'b0;
    check_eq("stream_accepts", 32'(accepts), 32'd5);
    guard = 0;
    while (sb_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check_eq("stream_drained", 32'(sb_q.size()), 32'd0);

    // Reset in CALC abandons the operation
    @(negedge clk);
    i_signed = 1'b0; i_dividend = 8'd200; i_divisor = 8'd7; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_ready", 32'(o_ready), 32'd1);
    check_eq("mid_rst_q",     32'(o_quotient), 32'd0);
    check_eq("mid_rst_r",     32'(o_remainder), 32'd0);
    stray = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (o_valid) stray = 1'b1;
    end
    check_eq("mid_rst_no_valid", 32'(stray), 32'd0);
    run_op(1'b0, 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0, 1'b0);

`ifdef DIV_ITER_ABORT_EN
    // Abort in CALC cycle 2: no result, previous outputs kept
    @(negedge clk);
    i_signed = 1'b0; i_dividend = 8'd200; i_divisor = 8'd7; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_abort = 1'b1;
    @(posedge clk);
    #1 i_abort = 1'b0;
    stray = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (o_valid) stray = 1'b1;
    end
    check_eq("abort_no_valid", 32'(stray), 32'd0);
    check_eq("abort_hold_q",   32'(o_quotient), 32'd3);
    check_eq("abort_hold_r",   32'(o_remainder), 32'd0);
    run_op(1'b0, 8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
